// File: rtl/hdc_pkg.sv
// Shared HDC encoder types, defaults and sizing helpers.
// Imported by the binder array and its rotator lanes.
package hdc_pkg;

  localparam int DEF_HV_DIM       = 1024;
  localparam int DEF_NUM_FEATURES = 16;

  typedef logic [DEF_HV_DIM-1:0] hv_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } binder_state_e;

  function automatic int nbeats(input int nf, input int nl);
    return (nf + nl - 1) / nl;
  endfunction

endpackage

// File: rtl/hv_rotator.sv
// Combinational circular rotator for one hypervector lane.
// dir_i = 0 rotates left, 1 rotates right; shamt_i < HV_DIM.
module hv_rotator #(
  parameter  int HV_DIM = 1024,
  localparam int SW     = $clog2(HV_DIM)
) (
  input  logic [HV_DIM-1:0] hv_i,
  input  logic [SW-1:0]     shamt_i,
  input  logic              dir_i,
  output logic [HV_DIM-1:0] hv_o
);

  logic [HV_DIM-1:0] rol, ror;

  // A shift by HV_DIM yields zero, so shamt 0 passes hv through.
  always_comb begin
    rol  = (hv_i << shamt_i)
         | (hv_i >> (HV_DIM - int'(shamt_i)));
    ror  = (hv_i >> shamt_i)
         | (hv_i << (HV_DIM - int'(shamt_i)));
    hv_o = dir_i ? ror : rol;
  end

endmodule

// File: rtl/enc_binder_array.sv
// Time-multiplexed feature binder: rotates each lane's level HV by its
// feature position and streams results through one register stage.
module enc_binder_array
  import hdc_pkg::*;
#(
  parameter int HV_DIM       = DEF_HV_DIM,
  parameter int NUM_FEATURES = DEF_NUM_FEATURES,
  parameter int NUM_LANES    = 4,
  parameter int SHIFT_STEP   = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_encoding,
  input  logic              dir,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] level_hv [0:NUM_LANES-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] shifted_hv [0:NUM_LANES-1],
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int NB = nbeats(NUM_FEATURES, NUM_LANES);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = $clog2(HV_DIM);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  binder_state_e     state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              dir_q, dir_d;
  logic              vld_q, last_q;
  logic [HV_DIM-1:0] hv_q [0:NUM_LANES-1];
  logic [HV_DIM-1:0] rot  [0:NUM_LANES-1];
  logic              accept, last_beat;

  assign in_ready   = (state_q == RUN) && (!vld_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign last_beat  = (beat_q == LAST_BEAT);
  assign out_valid  = vld_q;
  assign out_last   = last_q;
  assign shifted_hv = hv_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: if (start_encoding) begin
        state_d = RUN;
        dir_d   = dir;
        beat_d  = '0;
      end
      RUN: if (accept) begin
        if (last_beat) begin
          state_d = FLUSH;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      FLUSH: if (vld_q && out_ready && last_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift is derived from the beat counter; lanes past the end are zeroed.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [63:0]       feat, prod;
    logic [SW-1:0]     shamt;
    logic              active;
    logic [HV_DIM-1:0] rot_hv;

    always_comb begin
      feat   = 64'(beat_q) * 64'(NUM_LANES) + 64'(i);
      prod   = feat * 64'(SHIFT_STEP);
      shamt  = SW'(prod % 64'(HV_DIM));
      active = (feat < 64'(NUM_FEATURES));
    end

    hv_rotator #(.HV_DIM(HV_DIM)) u_rot (
      .hv_i    (level_hv[i]),
      .shamt_i (shamt),
      .dir_i   (dir_q),
      .hv_o    (rot_hv)
    );

    assign rot[i] = active ? rot_hv : '0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      dir_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) hv_q[i] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      dir_q   <= dir_d;
      if (accept) begin
        vld_q  <= 1'b1;
        last_q <= last_beat;
        for (int i = 0; i < NUM_LANES; i++) hv_q[i] <= rot[i];
      end else if (out_ready) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enc_binder_array.sv
// Bench for enc_binder_array: queue-based reference model plus
// directed literal passes and two boundary configurations.
module tb_enc_binder_array;

  localparam int W  = 16;
  localparam int NF = 6;
  localparam int NL = 4;
  localparam int SS = 3;
  localparam int NB = (NF + NL - 1) / NL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk1(input string nm, input bit act, input bit exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b required %0b", nm, act, exp);
  endtask

  task automatic chk16(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %04h required %04h", nm, act, exp);
  endtask

  // ---------------- main DUT ----------------
  logic          nrst = 1'b0, start = 1'b0, dir = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, out_last, busy, done;
  logic [W-1:0]  lvl [0:NL-1];
  logic [W-1:0]  shv [0:NL-1];
  bit            rr_en = 1'b0, or_force = 1'b1;

  enc_binder_array #(
    .HV_DIM(W), .NUM_FEATURES(NF), .NUM_LANES(NL), .SHIFT_STEP(SS)
  ) u_dut (
    .clk(clk), .nrst(nrst), .start_encoding(start), .dir(dir),
    .in_valid(in_valid), .in_ready(in_ready), .level_hv(lvl),
    .out_valid(out_valid), .out_ready(out_ready), .shifted_hv(shv),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    #2;
    out_ready = rr_en ? ($urandom_range(0, 2) != 0) : or_force;
  end

  // ---------------- boundary DUT B: step == HV_DIM ----------------
  logic          start_b = 1'b0, in_valid_b = 1'b0, rdy_b = 1'b1;
  logic          in_ready_b, out_valid_b, out_last_b, busy_b, done_b;
  logic [W-1:0]  lvl_b [0:3];
  logic [W-1:0]  shv_b [0:3];

  enc_binder_array #(
    .HV_DIM(W), .NUM_FEATURES(6), .NUM_LANES(4), .SHIFT_STEP(16)
  ) u_dut_b (
    .clk(clk), .nrst(nrst), .start_encoding(start_b), .dir(1'b0),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .level_hv(lvl_b),
    .out_valid(out_valid_b), .out_ready(rdy_b), .shifted_hv(shv_b),
    .out_last(out_last_b), .busy(busy_b), .done(done_b)
  );

  // ---------------- boundary DUT C: single beat ----------------
  logic          start_c = 1'b0, in_valid_c = 1'b0, rdy_c = 1'b1;
  logic          in_ready_c, out_valid_c, out_last_c, busy_c, done_c;
  logic [W-1:0]  lvl_c [0:5];
  logic [W-1:0]  shv_c [0:5];

  enc_binder_array #(
    .HV_DIM(W), .NUM_FEATURES(6), .NUM_LANES(6), .SHIFT_STEP(3)
  ) u_dut_c (
    .clk(clk), .nrst(nrst), .start_encoding(start_c), .dir(1'b0),
    .in_valid(in_valid_c), .in_ready(in_ready_c), .level_hv(lvl_c),
    .out_valid(out_valid_c), .out_ready(rdy_c), .shifted_hv(shv_c),
    .out_last(out_last_c), .busy(busy_c), .done(done_c)
  );

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] rot(input logic [W-1:0] v,
                                       input int s, input bit d);
    logic [W-1:0] r;
    for (int j = 0; j < W; j++)
      r[j] = d ? v[(j + s) % W] : v[(j - s + W) % W];
    return r;
  endfunction

  typedef struct packed {
    logic [NL-1:0][W-1:0] hv;
    logic                 last;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_FLUSH, M_DONE} mst_e;

  exp_t  q[$];
  mst_e  mst   = M_IDLE;
  bit    live  = 1'b0;
  bit    fresh = 1'b0;
  bit    mdir  = 1'b0;
  int    mbeat = 0;
  logic [NL-1:0][W-1:0] log_hv [$];
  bit    log_last [$];

  always @(negedge clk) begin
    exp_t e, p;
    bit   popped;
    logic [NL-1:0][W-1:0] cap;
    if (live) begin
      chk1("busy", busy, mst != M_IDLE);
      chk1("done", done, mst == M_DONE);
      chk1("in_ready", in_ready,
           mst == M_RUN && (q.size() == 0 || out_ready));
      chk1("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        for (int i = 0; i < NL; i++) chk16("lane_hv", shv[i], q[0].hv[i]);
        chk1("out_last", out_last, q[0].last);
      end
      if (fresh) begin
        chk1("rst_last", out_last, 1'b0);
        for (int i = 0; i < NL; i++) chk16("rst_hv", shv[i], '0);
      end
    end
    if (!nrst) begin
      mst = M_IDLE; q.delete(); mdir = 1'b0; mbeat = 0;
      live = 1'b1; fresh = 1'b1;
    end else if (live) begin
      fresh  = 1'b0;
      popped = 1'b0;
      p      = '0;
      if (out_valid && out_ready && q.size() != 0) begin
        for (int i = 0; i < NL; i++) cap[i] = shv[i];
        log_hv.push_back(cap);
        log_last.push_back(out_last);
        p = q.pop_front();
        popped = 1'b1;
      end
      case (mst)
        M_IDLE: if (start) begin
          mst = M_RUN; mdir = dir; mbeat = 0;
        end
        M_RUN: if (in_valid && in_ready) begin
          for (int i = 0; i < NL; i++) begin
            int f;
            f = mbeat * NL + i;
            e.hv[i] = (f >= NF) ? '0 : rot(lvl[i], (f * SS) % W, mdir);
          end
          e.last = (mbeat == NB - 1);
          q.push_back(e);
          mbeat++;
          if (mbeat == NB) mst = M_FLUSH;
        end
        M_FLUSH: if (popped && p.last) mst = M_DONE;
        M_DONE:  mst = M_IDLE;
        default: mst = M_IDLE;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [W-1:0] LEFT_EXP  [8];
  logic [W-1:0] RIGHT_EXP [8];
  logic [NL-1:0][W-1:0] ones;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit d);
    start = 1'b1;
    dir   = d;
    tick();
    start = 1'b0;
    dir   = ~d;
  endtask

  task automatic send_beat(input logic [NL-1:0][W-1:0] d,
                           input bit gap, input bit spur);
    bit ok = 1'b0;
    if (gap) repeat ($urandom_range(0, 2)) tick();
    for (int i = 0; i < NL; i++) lvl[i] = d[i];
    in_valid = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      start = spur ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk1("in_handshake", ok, 1'b1);
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk);
      ok = done;
      tick();
    end
    chk1("done_seen", ok, 1'b1);
  endtask

  task automatic chk_log(input int base, input logic [W-1:0] ref_v [8],
                         input string nm);
    if (log_hv.size() != base + 2) begin
      n_chk++;
      $display("FAIL %s_beats: got %0d required %0d",
               nm, log_hv.size() - base, 2);
      return;
    end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NL; i++)
        chk16(nm, log_hv[base + b][i], ref_v[b * NL + i]);
      chk1({nm, "_last"}, log_last[base + b], b == 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int  base;
    bit  ok;
    logic [NL-1:0][W-1:0] rd;
    LEFT_EXP  = '{16'h0001, 16'h0008, 16'h0040, 16'h0200,
                  16'h1000, 16'h8000, 16'h0000, 16'h0000};
    RIGHT_EXP = '{16'h0001, 16'h2000, 16'h0400, 16'h0080,
                  16'h0010, 16'h0002, 16'h0000, 16'h0000};
    for (int i = 0; i < NL; i++) ones[i] = 16'h0001;
    for (int i = 0; i < NL; i++) lvl[i] = '0;
    for (int i = 0; i < 4; i++) lvl_b[i] = '0;
    for (int i = 0; i < 6; i++) lvl_c[i] = 16'h0001;

    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    tick();

    // left pass
    base = log_hv.size();
    do_start(1'b0);
    send_beat(ones, 1'b0, 1'b0);
    send_beat(ones, 1'b0, 1'b0);
    wait_done();
    chk_log(base, LEFT_EXP, "left");

    // right pass, started right after the previous done
    base = log_hv.size();
    do_start(1'b1);
    send_beat(ones, 1'b0, 1'b0);
    send_beat(ones, 1'b0, 1'b0);
    wait_done();
    chk_log(base, RIGHT_EXP, "right");

    // start pulsed mid-pass is ignored
    base = log_hv.size();
    do_start(1'b0);
    send_beat(ones, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beat(ones, 1'b0, 1'b0);
    wait_done();
    chk_log(base, LEFT_EXP, "ign_start");

    // backpressure on beat0
    base = log_hv.size();
    do_start(1'b0);
    send_beat(ones, 1'b0, 1'b0);
    or_force = 1'b0;
    for (int i = 0; i < NL; i++) lvl[i] = 16'h0001;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk16("bp_hold", shv[1], 16'h0008);
      tick();
    end
    or_force = 1'b1;
    send_beat(ones, 1'b0, 1'b0);
    wait_done();
    chk_log(base, LEFT_EXP, "bp");

    // reset after beat0 accepted
    do_start(1'b1);
    send_beat(ones, 1'b0, 1'b0);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", out_valid, 1'b0);
    tick();
    base = log_hv.size();
    do_start(1'b0);
    send_beat(ones, 1'b0, 1'b0);
    send_beat(ones, 1'b0, 1'b0);
    wait_done();
    chk_log(base, LEFT_EXP, "after_rst");

    // randomized passes
    rr_en = 1'b1;
    for (int p = 0; p < 25; p++) begin
      do_start(1'($urandom_range(0, 1)));
      for (int b = 0; b < NB; b++) begin
        rd = {$urandom, $urandom};
        send_beat(rd, 1'b1, 1'b1);
      end
      wait_done();
    end
    rr_en = 1'b0;
    tick();

    // boundary B: rotation by a multiple of HV_DIM
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) lvl_b[i] = 16'($urandom);
      in_valid_b = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        ok = in_ready_b;
        tick();
      end
      in_valid_b = 1'b0;
      chk1("b_in_handshake", ok, 1'b1);
      @(negedge clk);
      chk1("b_valid", out_valid_b, 1'b1);
      chk1("b_last", out_last_b, b == 1);
      for (int i = 0; i < 4; i++)
        chk16("b_hv", shv_b[i], (b * 4 + i < 6) ? lvl_b[i] : 16'h0000);
      tick();
    end
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      ok = done_b;
      tick();
    end
    chk1("b_done", ok, 1'b1);

    // boundary C: all features in one beat
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    in_valid_c = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready_c;
      tick();
    end
    in_valid_c = 1'b0;
    chk1("c_in_handshake", ok, 1'b1);
    @(negedge clk);
    chk1("c_valid", out_valid_c, 1'b1);
    chk1("c_last", out_last_c, 1'b1);
    for (int i = 0; i < 6; i++) chk16("c_hv", shv_c[i], LEFT_EXP[i]);
    tick();
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      ok = done_c;
      tick();
    end
    chk1("c_done", ok, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/enc_binder_array.md
# enc_binder_array

Parametrised, time-multiplexed successor to the fixed per-feature binder pack. It binds `NUM_FEATURES` level hypervectors to their feature positions by circular rotation of `(f*SHIFT_STEP) mod HV_DIM`. Features stream through `NUM_LANES` parallel lanes over `ceil(NUM_FEATURES/NUM_LANES)` beats, using valid/ready handshakes on both sides and a run-time rotation direction. The block sits between the level-HV lookup and the bundler in the encoder.

## Interface
- `HV_DIM`, 1024, hypervector width in bits.
- `NUM_FEATURES`, 16, features per encoding.
- `NUM_LANES`, 4, features handled per beat (1..`NUM_FEATURES`).
- `SHIFT_STEP`, 1, rotation increment per feature index.
- `clk` in 1: single clock.
- `nrst` in 1: reset, synchronous, active-low.
- `start_encoding` in 1: starts an encoding pass; honoured only in IDLE.
- `dir` in 1: rotation direction, 0 = left, 1 = right; sampled with `start_encoding`.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid & in_ready`.
- `level_hv` in `[HV_DIM-1:0]` x `[0:NUM_LANES-1]`: lane i carries feature `beat*NUM_LANES+i`.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts.
- `shifted_hv` out `[HV_DIM-1:0]` x `[0:NUM_LANES-1]`: bound HVs.
- `out_last` out 1: qualifies the final beat of a pass.
- `busy` out 1: high whenever not IDLE.
- `done` out 1: one-cycle pulse after the final beat is consumed.

## Operation
- FSM states:
  - IDLE: `in_ready`=0. On `start_encoding`: latch `dir`, clear beat counter, go to RUN.
  - RUN: accept beats. When the accepted beat is the last one (`beat == NBEATS-1`), go to FLUSH.
  - FLUSH: hold until the final output beat is consumed (`out_valid & out_ready & out_last`), then go to DONE.
  - DONE: assert `done` for one cycle, then return to IDLE.
- `NBEATS = ceil(NUM_FEATURES/NUM_LANES)`. The beat counter is `$clog2(NBEATS)` bits wide, minimum 1.
- Shift for lane i of beat b:
  - `f = b*NUM_LANES+i`, `s = (f*SHIFT_STEP) mod HV_DIM`.
  - The product is computed at sufficient width; there is no overflow before the mod.
- Left rotate: `out[j] = in[(j-s) mod HV_DIM]`. Right rotate: `out[j] = in[(j+s) mod HV_DIM]`.
- Lanes with `f >= NUM_FEATURES` (partial last beat) output all-zero, whatever the input.
- Output is a single register stage. `in_ready = (state==RUN) & (!out_valid | out_ready)`.
- `out_valid` and `shifted_hv` stay stable while `out_valid & !out_ready`.
- `start_encoding` outside IDLE is ignored. `dir` changes mid-pass have no effect.
- `nrst`=0 in any state:
  - next cycle is IDLE; beat counter 0; latched `dir` 0;
  - `out_valid`, `out_last`, `done`, `busy` all 0; `shifted_hv` all zero;
  - any in-flight beat is discarded.

## Timing
- Reset values: every output 0.
- Latency: a beat accepted at edge k appears on `shifted_hv` with `out_valid`=1 after edge k.
- Throughput: one beat per cycle while `out_ready`=1.
- `busy` rises the cycle after `start_encoding` is sampled in IDLE.
- `in_ready` can first be high one cycle after the start edge.
- `done` is high exactly one cycle, the cycle after the last-beat handshake. `busy` drops with the same edge that ends DONE.
- Back-to-back passes: a new `start_encoding` is accepted the first cycle back in IDLE.
- Minimum pass length: `NBEATS+3` cycles.

## Structure
- Shared package `hdc_pkg`:
  - `HV_DIM`, `NUM_FEATURES` defaults;
  - `hv_t` typedef;
  - `binder_state_e` enum (IDLE, RUN, FLUSH, DONE);
  - `NBEATS` function.
- Sub-module `hv_rotator`: combinational barrel rotator with inputs hv, shift amount `$clog2(HV_DIM)` bits and dir. It is instantiated `NUM_LANES` times.
- Shift values are computed per lane from the beat counter. There is no per-feature shift table.

## Test plan
Common configuration: `HV_DIM`=16, `NUM_FEATURES`=6, `NUM_LANES`=4, `SHIFT_STEP`=3, all lanes `16'h0001`.
- **Left pass:** `dir`=0, `out_ready`=1.
  - Beat0 → 0001, 0008, 0040, 0200.
  - Beat1 → 1000, 8000, 0000, 0000 with `out_last`=1.
  - `done` pulses once.
- **Right pass:** `dir`=1, same stimulus.
  - Beat0 → 0001, 2000, 0400, 0080.
  - Beat1 → 0010, 0002, 0000, 0000.
- **Backpressure:** hold `out_ready`=0 for 5 cycles on beat0.
  - `shifted_hv` stays stable and `in_ready`=0.
  - Release → beat1 follows next cycle; no beat lost or duplicated.
- **Ignored start:** `start_encoding` pulsed during RUN → no restart, beat count unchanged. Pulse in the cycle after `done` → new pass starts.
- **Reset mid-pass:** `nrst`=0 after beat0 accepted → next cycle all outputs 0, state IDLE. The next pass starts again from feature 0.
- **Boundary:** `SHIFT_STEP`=16 (s ≡ 0) → outputs equal inputs. `NUM_LANES`=`NUM_FEATURES`=6 → single beat with `out_last`=1.
